alu_pipe: RTL and testbench
===========================

# alu_pipe

Parametrised, handshaked successor to the team's single-cycle 16-bit ALU. It adds a registered output stage, a persistent flag register (C/Z/N/V) that enables multi-word carry/borrow chains, shift operations, and a multi-cycle unsigned shift-add multiplier. It sits between the datapath operand registers and the writeback stage, with valid/ready handshakes on both sides.

## Interface
- WIDTH, 16, operand/result width; legal range 4–64.
- MUL_EN, 1, 1 = ops 12/13 use the multi-cycle multiplier; 0 = ops 12/13 complete in one cycle with Y=0 and flags computed from Y=0.
- Clk  in  1  single clock, rising edge.
- Rst  in  1  synchronous, active-high reset.
- InValid  in  1  operand/op presented.
- InReady  out  1  block can accept this cycle; transfer when InValid && InReady.
- A, B  in  WIDTH  operands.
- Op  in  4  operation select.
- CIn  in  1  external carry-in (ADD, SETC only).
- OutValid  out  1  Y/Flags hold a completed result.
- OutReady  in  1  consumer takes result when OutValid && OutReady.
- Y  out  WIDTH  result register.
- Flags  out  4  {V,N,Z,C}, registered with Y.
- Busy  out  1  multiplier iterating.

## Operation
- Ops: 0 ADD A+B+CIn; 1 ADC A+B+CF; 2 SUB A+~B+1; 3 SBB A+~B+CF; 4 AND; 5 OR; 6 XOR; 7 NOT ~A; 8 SHL A<<1, C=A[MSB]; 9 SHR logical, C=A[0]; 10 ASR, C=A[0]; 11 CMP: flags from A−B, Y=A; 12 MUL: Y=low WIDTH bits of A*B (unsigned), C=|high half; 13 MULH: Y=high WIDTH bits, C=0; 14 PASSB: Y=B; 15 SETC: Y=A, C=CIn.
- CF is the internal copy of Flags[0]. ADC/SBB use CF as of the accept cycle. SUB/SBB/CMP: C=1 means no borrow.
- Arithmetic sum is computed in WIDTH+1 bits; C = bit WIDTH.
- V is signed overflow for ops 0–3 and 11, and 0 for all others.
- Z = (Y==0), N = Y[WIDTH-1] for all ops. For CMP only, Z/N reflect A−B, not Y.
- SHL/SHR/ASR shift by exactly 1.
- All four flags commit together with Y on every completed op. Flags change only on that commit.
- States: IDLE (accepting), MUL (iterating), with the output register valid/empty tracked by OutValid.
  - IDLE → MUL on accepting op 12/13 with MUL_EN=1. Operands are latched on entry.
  - MUL → IDLE after WIDTH iterations. One multiplier bit per cycle (shift-add into a 2*WIDTH product). A counter of clog2(WIDTH+1) bits counts the iterations.
- InReady = !Rst && state==IDLE && (!OutValid || OutReady).
- Output register loads on a single-cycle accept or on the final MUL iteration. Otherwise it clears OutValid when drained.
- Op encodings are fully decoded; there are no illegal values.

## Timing
- Reset values: OutValid=0, Y=0, Flags=0 (CF=0), Busy=0, state IDLE, iteration counter 0. InReady=0 while Rst=1 and 1 in the first cycle after deassertion.
- Rst mid-multiply aborts the operation. The partial product is discarded and no result is produced.
- Single-cycle ops: latency 1. A result accepted in cycle t gives OutValid=1 in cycle t+1. Back-to-back accepts run at full throughput while OutReady=1.
- Carry chain: ADC/SBB accepted in cycle t+1 sees CF from the op accepted in cycle t.
- MUL/MULH: accepted in cycle t; Busy=1 and InReady=0 in cycles t+1..t+WIDTH; OutValid=1 in cycle t+WIDTH+1.
- Backpressure: while OutValid && !OutReady, Y and Flags hold stable and InReady=0.
- Simultaneous drain and accept: the old result leaves and the new one loads in the same edge, with no bubble.
- OutReady has no effect while OutValid=0. Inputs are ignored when InReady=0.

## Test plan
- WIDTH=16. ADD A=0xFFFF B=0x0001 CIn=0 → next cycle Y=0x0000, Flags C=1 Z=1 N=0 V=0.
- 32-bit chain: ADD 0xFFFF+0x0001, then ADC 0x0000+0x0000 back-to-back → Y=0x0000 then 0x0001, OutValid on consecutive cycles.
- SUB 0x8000−0x0001 → Y=0x7FFF, C=1, V=1, N=0. CMP 0x0005,0x0005 → Y=0x0005, Z=1, C=1.
- MUL 0x1234*0x0100 accepted in cycle t → Busy and InReady low for 16 cycles, OutValid in cycle t+17, Y=0x3400, C=1. MULH on the same operands → Y=0x0012, C=0.
- Backpressure: OutReady=0, ADD then XOR presented → first result held unchanged, InReady=0. Raise OutReady → XOR accepted in the same cycle as the drain, its result appears next cycle.
- Assert Rst in the 5th MUL iteration → next cycle OutValid=0, Flags=0, Busy=0. Then ADD 0x0002+0x0003 → Y=0x0005 with latency 1.

Source files
------------

// File: rtl/alu_pipe.sv
// Pipelined, handshaked ALU. It has a registered result, persistent C/Z/N/V flags,
// and an optional shift-add multiplier that produces one bit per cycle.
module alu_pipe #(
    parameter int WIDTH  = 16,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       Op,
    input  logic             CIn,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Y,
    output logic [3:0]       Flags,
    output logic             Busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, MUL} state_t;

    state_t             state, state_next;
    logic [CW-1:0]      iter_cnt;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod;
    logic               mul_high;

    logic               accept, start_mul, mul_last, cf;
    logic [WIDTH-1:0]   b_op;
    logic               c_in;
    logic [WIDTH:0]     sum;
    logic               arith_v;
    logic [WIDTH-1:0]   alu_y, zn_src;
    logic               alu_c, alu_v;
    logic [3:0]         alu_flags;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_step;
    logic [WIDTH-1:0]   mul_y;
    logic               mul_c;
    logic [3:0]         mul_flags;

    assign cf        = Flags[0];
    assign InReady   = !Rst && (state == IDLE) && (!OutValid || OutReady);
    assign accept    = InValid && InReady;
    assign start_mul = accept && (Op == 4'd12 || Op == 4'd13) && MUL_EN;
    assign mul_last  = (state == MUL) && (iter_cnt == CW'(WIDTH - 1));
    assign Busy      = (state == MUL);

    // Subtract-type ops reuse the adder as A + ~B + carry.
    always_comb begin
        b_op = B;
        c_in = 1'b0;
        case (Op)
            4'd0:          c_in = CIn;
            4'd1:          c_in = cf;
            4'd2, 4'd11: begin b_op = ~B; c_in = 1'b1; end
            4'd3:        begin b_op = ~B; c_in = cf;   end
            default:       c_in = 1'b0;
        endcase
    end

    assign sum     = {1'b0, A} + {1'b0, b_op} + {{WIDTH{1'b0}}, c_in};
    assign arith_v = (A[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);

    always_comb begin
        alu_y = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (Op)
            4'd0, 4'd1, 4'd2, 4'd3: begin
                alu_y = sum[WIDTH-1:0];
                alu_c = sum[WIDTH];
                alu_v = arith_v;
            end
            4'd4:  alu_y = A & B;
            4'd5:  alu_y = A | B;
            4'd6:  alu_y = A ^ B;
            4'd7:  alu_y = ~A;
            4'd8:  begin alu_y = {A[WIDTH-2:0], 1'b0};     alu_c = A[WIDTH-1]; end
            4'd9:  begin alu_y = {1'b0, A[WIDTH-1:1]};     alu_c = A[0];       end
            4'd10: begin alu_y = {A[WIDTH-1], A[WIDTH-1:1]}; alu_c = A[0];     end
            4'd11: begin
                alu_y = A;
                alu_c = sum[WIDTH];
                alu_v = arith_v;
            end
            4'd14: alu_y = B;
            4'd15: begin alu_y = A; alu_c = CIn; end
            default: begin alu_y = '0; alu_c = 1'b0; end
        endcase
    end

    // CMP reports Z/N of the difference while passing A through as the result.
    assign zn_src    = (Op == 4'd11) ? sum[WIDTH-1:0] : alu_y;
    assign alu_flags = {alu_v, zn_src[WIDTH-1], (zn_src == '0), alu_c};

    // The multiplier accumulates into the upper half and shifts right, retiring one bit of B per step.
    assign mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    assign prod_step = {mul_sum, prod[WIDTH-1:1]};
    assign mul_y     = mul_high ? prod_step[2*WIDTH-1:WIDTH] : prod_step[WIDTH-1:0];
    assign mul_c     = mul_high ? 1'b0 : |prod_step[2*WIDTH-1:WIDTH];
    assign mul_flags = {1'b0, mul_y[WIDTH-1], (mul_y == '0), mul_c};

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_mul) state_next = MUL;
            MUL:     if (mul_last)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= IDLE;
            iter_cnt <= '0;
            mcand    <= '0;
            prod     <= '0;
            mul_high <= 1'b0;
            OutValid <= 1'b0;
            Y        <= '0;
            Flags    <= '0;
        end else begin
            state <= state_next;

            if (start_mul) begin
                mcand    <= A;
                prod     <= {{WIDTH{1'b0}}, B};
                mul_high <= Op[0];
                iter_cnt <= '0;
            end else if (state == MUL) begin
                prod     <= prod_step;
                iter_cnt <= mul_last ? '0 : iter_cnt + CW'(1);
            end

            if (accept && !start_mul) begin
                OutValid <= 1'b1;
                Y        <= alu_y;
                Flags    <= alu_flags;
            end else if (mul_last) begin
                OutValid <= 1'b1;
                Y        <= mul_y;
                Flags    <= mul_flags;
            end else if (OutReady) begin
                OutValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe. It runs directed scenarios and then random traffic, and checks
// every cycle against an arithmetic reference model.
module tb_alu_pipe;

    localparam int  W    = 16;
    localparam longint MASK = 64'hFFFF;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [3:0]    op = '0;
    logic          cin = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  y;
    logic [3:0]    flags;
    logic          busy;

    int checks = 0;
    int errors = 0;

    // Reference model state, tracked at the level of transactions and results.
    logic          m_ov = 1'b0;
    longint        m_y = 0;
    logic [3:0]    m_fl = '0;
    int            m_busy_left = 0;
    longint        m_pend_y = 0;
    logic [3:0]    m_pend_fl = '0;

    alu_pipe #(.WIDTH(W), .MUL_EN(1'b1)) dut (
        .Clk(clk), .Rst(rst), .InValid(in_valid), .InReady(in_ready),
        .A(a), .B(b), .Op(op), .CIn(cin), .OutValid(out_valid),
        .OutReady(out_ready), .Y(y), .Flags(flags), .Busy(busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint to_signed(input longint v);
        return (v >= 32768) ? v - 65536 : v;
    endfunction

    function automatic void ref_alu(input int o, input longint ra, input longint rb, input int ci,
                                    input int cfl, output longint ry, output logic [3:0] fl);
        longint sres, d, p, zn;
        int c;
        bit v;
        c = 0;
        sres = 0;
        ry = 0;
        case (o)
            0:  begin d = ra + rb + ci;  ry = d & MASK; c = int'((d >> 16) & 1); sres = to_signed(ra) + to_signed(rb) + ci; end
            1:  begin d = ra + rb + cfl; ry = d & MASK; c = int'((d >> 16) & 1); sres = to_signed(ra) + to_signed(rb) + cfl; end
            2:  begin d = ra - rb; ry = d & MASK; c = (d >= 0); sres = to_signed(ra) - to_signed(rb); end
            3:  begin d = ra - rb - (1 - cfl); ry = d & MASK; c = (d >= 0); sres = to_signed(ra) - to_signed(rb) - (1 - cfl); end
            4:  ry = ra & rb;
            5:  ry = ra | rb;
            6:  ry = ra ^ rb;
            7:  ry = (~ra) & MASK;
            8:  begin ry = (ra << 1) & MASK; c = int'((ra >> 15) & 1); end
            9:  begin ry = ra >> 1; c = int'(ra & 1); end
            10: begin ry = (ra >> 1) | (ra & 64'h8000); c = int'(ra & 1); end
            11: begin ry = ra; c = (ra >= rb); sres = to_signed(ra) - to_signed(rb); end
            12: begin p = ra * rb; ry = p & MASK; c = ((p >> 16) != 0); end
            13: begin p = ra * rb; ry = p >> 16; c = 0; end
            14: ry = rb;
            default: begin ry = ra; c = ci; end
        endcase
        v  = (o <= 3 || o == 11) && (sres < -32768 || sres > 32767);
        zn = (o == 11) ? ((ra - rb) & MASK) : ry;
        fl = {v, zn[15], (zn == 0), c[0]};
    endfunction

    // One clock cycle. Drive the inputs, check the DUT against the model at the falling edge,
    // then advance the model at the rising edge.
    task automatic applyStimulus(input logic r, input logic v, input logic [3:0] o,
                                 input logic [W-1:0] ia, input logic [W-1:0] ib,
                                 input logic ci, input logic ordy);
        logic   exp_ready, acc;
        longint ry;
        logic [3:0] fl;
        rst = r; in_valid = v; op = o; a = ia; b = ib; cin = ci; out_ready = ordy;
        @(negedge clk);
        exp_ready = !r && (m_busy_left == 0) && (!m_ov || ordy);
        checkOutput("in_ready", in_ready, exp_ready);
        checkOutput("busy", busy, m_busy_left != 0);
        checkOutput("out_valid", out_valid, m_ov);
        checkOutput("y", y, m_y);
        checkOutput("flags", flags, m_fl);
        acc = v && exp_ready;
        @(posedge clk);
        if (r) begin
            m_ov = 0; m_y = 0; m_fl = '0; m_busy_left = 0;
        end else begin
            if (m_ov && ordy) m_ov = 0;
            if (acc) begin
                ref_alu(int'(o), longint'(ia), longint'(ib), int'(ci), int'(m_fl[0]), ry, fl);
                if (o == 4'd12 || o == 4'd13) begin
                    m_busy_left = W;
                    m_pend_y = ry; m_pend_fl = fl;
                end else begin
                    m_y = ry; m_fl = fl; m_ov = 1;
                end
            end else if (m_busy_left > 0) begin
                m_busy_left--;
                if (m_busy_left == 0) begin
                    m_y = m_pend_y; m_fl = m_pend_fl; m_ov = 1;
                end
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 4'd0, '0, '0, 0, 1);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic [3:0]   ro;
        $display("[TB] start");
        applyStimulus(1, 0, 4'd0, '0, '0, 0, 1);
        applyStimulus(1, 1, 4'd0, 16'h1111, 16'h2222, 0, 1);
        idle(1);

        // Carry chain: ADD then ADC back to back.
        applyStimulus(0, 1, 4'd0, 16'hFFFF, 16'h0001, 0, 1);
        applyStimulus(0, 1, 4'd1, 16'h0000, 16'h0000, 0, 1);
        idle(2);
        applyStimulus(0, 1, 4'd2, 16'h8000, 16'h0001, 0, 1);
        applyStimulus(0, 1, 4'd11, 16'h0005, 16'h0005, 0, 1);
        applyStimulus(0, 1, 4'd3, 16'h0003, 16'h0005, 0, 1);
        applyStimulus(0, 1, 4'd3, 16'h0000, 16'h0000, 0, 1);
        applyStimulus(0, 1, 4'd10, 16'h8001, 16'h0000, 0, 1);
        applyStimulus(0, 1, 4'd8, 16'h8001, 16'h0000, 0, 1);
        applyStimulus(0, 1, 4'd15, 16'h1234, 16'h0000, 1, 1);
        idle(1);

        // Multiplier, low and high halves.
        applyStimulus(0, 1, 4'd12, 16'h1234, 16'h0100, 0, 1);
        idle(W + 2);
        applyStimulus(0, 1, 4'd13, 16'h1234, 16'h0100, 0, 1);
        idle(W + 2);
        applyStimulus(0, 1, 4'd12, 16'hFFFF, 16'hFFFF, 0, 1);
        idle(W + 2);

        // Backpressure, then a drain and an accept on the same edge.
        applyStimulus(0, 1, 4'd0, 16'h0001, 16'h0002, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 4'd6, 16'h00F0, 16'h0FF0, 0, 0);
        applyStimulus(0, 1, 4'd6, 16'h00F0, 16'h0FF0, 0, 1);
        idle(2);

        // Reset during the fifth multiplier iteration.
        applyStimulus(0, 1, 4'd12, 16'h1234, 16'h5678, 0, 1);
        idle(4);
        applyStimulus(1, 0, 4'd0, '0, '0, 0, 1);
        applyStimulus(0, 1, 4'd0, 16'h0002, 16'h0003, 0, 1);
        idle(2);

        // Random traffic with occasional backpressure and resets.
        for (int i = 0; i < 1500; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 7) == 0) ra = 16'hFFFF;
            if ($urandom_range(0, 7) == 0) rb = 16'h8000;
            ro = 4'($urandom_range(0, 15));
            applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, ro, ra, rb,
                          1'($urandom), $urandom_range(0, 9) < 7);
        end
        idle(W + 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
